// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the ALU command sequencer and its ALU.
package alu_pkg;

  localparam int unsigned SELOP_W = 3;

  localparam logic [SELOP_W-1:0] OP_ADD = 3'b000;
  localparam logic [SELOP_W-1:0] OP_SUB = 3'b001;
  localparam logic [SELOP_W-1:0] OP_AND = 3'b010;
  localparam logic [SELOP_W-1:0] OP_OR  = 3'b011;
  localparam logic [SELOP_W-1:0] OP_XOR = 3'b100;
  localparam logic [SELOP_W-1:0] OP_NOT = 3'b101;
  localparam logic [SELOP_W-1:0] OP_SHL = 3'b110;
  localparam logic [SELOP_W-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/processing_unit.sv
// Combinational N-bit ALU: add/sub with carry/borrow, bitwise logic and 1-bit shifts.
module processing_unit
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]       dataa,
  input  logic [N-1:0]       datab,
  input  logic [SELOP_W-1:0] selop,
  output logic [N-1:0]       result,
  output logic               cout
);

  logic [N:0] sum;
  logic [N:0] diff;

  assign sum  = {1'b0, dataa} + {1'b0, datab};
  // Top bit of the extended difference is the borrow (set when dataa < datab).
  assign diff = {1'b0, dataa} - {1'b0, datab};

  always_comb begin
    result = '0;
    cout   = 1'b0;
    case (selop)
      OP_ADD: begin
        result = sum[N-1:0];
        cout   = sum[N];
      end
      OP_SUB: begin
        result = diff[N-1:0];
        cout   = diff[N];
      end
      OP_AND: result = dataa & datab;
      OP_OR:  result = dataa | datab;
      OP_XOR: result = dataa ^ datab;
      OP_NOT: result = ~dataa;
      OP_SHL: begin
        result = {dataa[N-2:0], 1'b0};
        cout   = dataa[N-1];
      end
      OP_SHR: begin
        result = {1'b0, dataa[N-1:1]};
        cout   = dataa[0];
      end
      default: begin
        result = '0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues handshaked commands to processing_unit, holds operands for EXEC_CYCLES,
// captures result/cout and returns them over a response handshake.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CW          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [N-1:0]       cmd_a,
  input  logic [N-1:0]       cmd_b,
  input  logic [SELOP_W-1:0] cmd_op,
  input  logic               cmd_chain,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_result,
  output logic               rsp_cout,
  output logic [CW-1:0]      op_count
);

  localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(EXEC_CYCLES - 1);

  if (EXEC_CYCLES == 0) begin : g_bad_exec_cycles
    $error("alu_cmd_sequencer: EXEC_CYCLES must be at least 1");
  end

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]         a_q, a_d;
  logic [N-1:0]         b_q, b_d;
  logic [SELOP_W-1:0]   op_q, op_d;
  logic [N-1:0]         acc_q, acc_d;
  logic [N-1:0]         res_q, res_d;
  logic                 cout_q, cout_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic [N-1:0]         pu_result;
  logic                 pu_cout;

  processing_unit #(
    .N(N)
  ) u_pu (
    .dataa (a_q),
    .datab (b_q),
    .selop (op_q),
    .result(pu_result),
    .cout  (pu_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    acc_d       = acc_q;
    res_d       = res_q;
    cout_d      = cout_q;
    count_d     = count_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          a_d         = cmd_chain ? acc_q : cmd_a;
          b_d         = cmd_b;
          op_d        = cmd_op;
          cnt_d       = CntLoad;
          cmd_ready_d = 1'b0;
          state_d     = StExec;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          res_d       = pu_result;
          acc_d       = pu_result;
          cout_d      = pu_cout;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        // Command acceptance waits for IDLE, so ready rises together with valid falling.
        if (rsp_ready) begin
          count_d     = count_q + CW'(1);
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = res_q;
  assign rsp_cout   = cout_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: two sequencer instances (EXEC_CYCLES=1/CW=8 and EXEC_CYCLES=3/CW=2).
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       cmd_valid, cmd_ready, cmd_chain, rsp_valid, rsp_ready, rsp_cout;
  logic [7:0] cmd_a, cmd_b, rsp_result, op_count;
  logic [2:0] cmd_op;

  logic       w_cmd_valid, w_cmd_ready, w_cmd_chain, w_rsp_valid, w_rsp_ready, w_rsp_cout;
  logic [7:0] w_cmd_a, w_cmd_b, w_rsp_result;
  logic [2:0] w_cmd_op;
  logic [1:0] w_op_count;

  alu_cmd_sequencer #(.N(8), .EXEC_CYCLES(1), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .op_count(op_count)
  );

  alu_cmd_sequencer #(.N(8), .EXEC_CYCLES(3), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_a(w_cmd_a), .cmd_b(w_cmd_b), .cmd_op(w_cmd_op), .cmd_chain(w_cmd_chain),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_result(w_rsp_result),
    .rsp_cout(w_rsp_cout), .op_count(w_op_count)
  );

  typedef struct {
    logic [7:0] res;
    logic       cout;
    int         acc_cyc;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  int   mcount0 = 0;
  int   mcount1 = 0;
  bit   seen0 = 0;
  bit   seen1 = 0;
  int   last_hs0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    tot_cnt++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Monitor for the EXEC_CYCLES=1 instance.
  initial forever begin
    @(negedge clk);
    if (rst_n && rsp_valid) begin
      if (q0.size() == 0) begin
        fail_now("dut_unexpected_response");
      end else begin
        if (!seen0) begin
          seen0 = 1;
          if (q0[0].lat >= 0) check("dut_latency", 32'(cyc - q0[0].acc_cyc), 32'(q0[0].lat));
        end
        if (rsp_ready) begin
          check("dut_result", 32'(rsp_result), 32'(q0[0].res));
          check("dut_cout", 32'(rsp_cout), 32'(q0[0].cout));
          check("dut_op_count", 32'(op_count), 32'(mcount0 % 256));
          mcount0++;
          last_hs0 = cyc;
          void'(q0.pop_front());
          seen0 = 0;
        end
      end
    end
  end

  // Monitor for the EXEC_CYCLES=3, CW=2 instance.
  initial forever begin
    @(negedge clk);
    if (rst_n && w_rsp_valid) begin
      if (q1.size() == 0) begin
        fail_now("dut2_unexpected_response");
      end else begin
        if (!seen1) begin
          seen1 = 1;
          if (q1[0].lat >= 0) check("dut2_latency", 32'(cyc - q1[0].acc_cyc), 32'(q1[0].lat));
        end
        if (w_rsp_ready) begin
          check("dut2_result", 32'(w_rsp_result), 32'(q1[0].res));
          check("dut2_cout", 32'(w_rsp_cout), 32'(q1[0].cout));
          check("dut2_op_count", 32'(w_op_count), 32'(mcount1 % 4));
          mcount1++;
          void'(q1.pop_front());
          seen1 = 0;
        end
      end
    end
  end

  task automatic send(input int sel, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic ch, input logic [7:0] er,
                      input logic ec, input int lat, output int acc);
    int   n = 0;
    bit   got = 0;
    exp_t e;
    acc = -1;
    if (sel == 0) begin
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch; cmd_valid = 1'b1;
    end else begin
      w_cmd_a = a; w_cmd_b = b; w_cmd_op = op; w_cmd_chain = ch; w_cmd_valid = 1'b1;
    end
    while (!got && n < 50) begin
      @(negedge clk);
      if ((sel == 0) ? cmd_ready : w_cmd_ready) got = 1;
      else n++;
    end
    if (!got) begin
      fail_now("accept_timeout");
    end else begin
      acc       = cyc;
      e.res     = er;
      e.cout    = ec;
      e.acc_cyc = cyc;
      e.lat     = lat;
      if (sel == 0) q0.push_back(e);
      else q1.push_back(e);
      @(posedge clk);
      #1;
    end
    cmd_valid   = 1'b0;
    w_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  logic [7:0] v_res[8] = '{8'h03, 8'h01, 8'h00, 8'h03, 8'h03, 8'hFD, 8'h04, 8'h01};
  logic [7:0] w_a[5]   = '{8'h55, 8'h03, 8'hF0, 8'h81, 8'h99};
  logic [7:0] w_b[5]   = '{8'h03, 8'h05, 8'h0F, 8'h00, 8'h40};
  logic [2:0] w_op[5]  = '{OP_ADD, OP_SUB, OP_XOR, OP_SHL, OP_OR};
  logic       w_ch[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] w_res[5] = '{8'h03, 8'hFE, 8'hFF, 8'h02, 8'h42};
  logic       w_co[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int acc, acc_y;
    cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; cmd_chain = 0; rsp_ready = 1;
    w_cmd_valid = 0; w_cmd_a = 0; w_cmd_b = 0; w_cmd_op = 0; w_cmd_chain = 0; w_rsp_ready = 1;

    // Reset values while held and after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_dut2_op_count", 32'(w_op_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Single zero add.
    send(0, 8'h00, 8'h00, OP_ADD, 1'b0, 8'h00, 1'b0, 2, acc);
    wait_drain();
    check("single_op_count", 32'(op_count), 32'd1);

    // Reset during EXEC aborts the command.
    @(posedge clk); #1;
    cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = OP_ADD; cmd_chain = 0; cmd_valid = 1;
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_result", 32'(rsp_result), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    mcount0 = 0; mcount1 = 0; seen0 = 0; seen1 = 0;
    repeat (3) @(negedge clk);
    check("midrst_no_response", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // All opcodes on a=2, b=1, back-to-back.
    for (int i = 0; i < 8; i++) begin
      send(0, 8'h02, 8'h01, 3'(i), 1'b0, v_res[i], 1'b0, 2, acc);
    end
    wait_drain();
    check("vectors_op_count", 32'(op_count), 32'd8);

    // Backpressure with a second command waiting.
    @(posedge clk); #1 rsp_ready = 0;
    send(0, 8'd10, 8'd20, OP_ADD, 1'b0, 8'd30, 1'b0, 2, acc);
    fork
      send(0, 8'd5, 8'd9, OP_SUB, 1'b0, 8'hFC, 1'b1, 2, acc_y);
      begin
        int n = 0;
        while (!rsp_valid && n < 10) begin
          @(negedge clk);
          n++;
        end
        repeat (10) begin
          @(negedge clk);
          check("bp_result_stable", 32'(rsp_result), 32'd30);
          check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
          check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1;
      end
    join
    check("bp_accept_after_hs", 32'(acc_y), 32'(last_hs0 + 1));
    wait_drain();
    check("bp_op_count", 32'(op_count), 32'd10);

    // Chaining: FF+01 wraps to 00, then 00+05.
    @(posedge clk); #1;
    send(0, 8'hFF, 8'h01, OP_ADD, 1'b0, 8'h00, 1'b1, 2, acc);
    send(0, 8'h33, 8'h05, OP_ADD, 1'b1, 8'h05, 1'b0, 2, acc);
    wait_drain();
    check("chain_op_count", 32'(op_count), 32'd12);

    // Second instance: first command chains from acc=0, counter wraps at 4.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      send(1, w_a[i], w_b[i], w_op[i], w_ch[i], w_res[i], w_co[i], 4, acc);
    end
    wait_drain();
    check("wrap_op_count_final", 32'(w_op_count), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
